// File: rtl/hex_pkg.sv
// Shared constants and types for the seven-segment read-back block.
// Segment codes are active-low, bit 6 = g ... bit 0 = a.
package hex_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // WAIT: nothing accepted since reset, LOCK: legal digit held, BAD: illegal pattern held
  typedef enum logic [1:0] {
    WAIT = 2'd0,
    LOCK = 2'd1,
    BAD  = 2'd2
  } state_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational seven-segment decoder: maps an active-low pattern to
// {legal, value}. Illegal patterns report value 0.
module seg_decode
  import hex_pkg::*;
(
  input  logic [6:0] hex,
  output logic       legal,
  output logic [3:0] value
);

  // Table lookup against the ten legal codes
  always_comb begin
    legal = 1'b1;
    value = 4'd0;
    unique case (hex)
      SEG_0:   value = 4'd0;
      SEG_1:   value = 4'd1;
      SEG_2:   value = 4'd2;
      SEG_3:   value = 4'd3;
      SEG_4:   value = 4'd4;
      SEG_5:   value = 4'd5;
      SEG_6:   value = 4'd6;
      SEG_7:   value = 4'd7;
      SEG_8:   value = 4'd8;
      SEG_9:   value = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/hex_reader.sv
// Reads back a seven-segment display pattern: debounces HEX for
// STABLE_CYCLES edges, decodes it, tracks the accepted digit and flags
// +1 steps, 9->0 wraps and other jumps as one-cycle pulses.
// Optional feature: define HEX_READER_JUMP_EN to enable the jump output;
// without it jump is tied low and its compare logic is absent.
module hex_reader
  import hex_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 3  // legal 1..15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] HEX,
  output logic [3:0] digit,
  output logic       valid,
  output logic       err,
  output logic       incrOut,
  output logic       wrapOut,
  output logic       jump
);

  localparam logic [3:0] SAT = 4'(STABLE_CYCLES);

  logic [6:0] sample;
  logic [3:0] cnt;
  logic       accept;
  logic       legal;
  logic [3:0] value;
  logic [3:0] digit_inc;
  state_t     state, state_nxt;

  // Acceptance is the edge on which the counter steps from SAT-1 to SAT;
  // once saturated the same pattern is not accepted again.
  assign accept = (HEX == sample) && (cnt == SAT - 4'd1);

  // sample is equal to HEX whenever accept is high, so decoding the
  // registered copy keeps the input port off the decode path
  seg_decode u_dec (
    .hex   (sample),
    .legal (legal),
    .value (value)
  );

  assign digit_inc = (digit == 4'd9) ? 4'd0 : digit + 4'd1;

  // Sample register and stability counter
  always_ff @(posedge clk) begin
    if (reset) begin
      sample <= SEG_BLANK;
      cnt    <= 4'd0;
    end else begin
      sample <= HEX;
      if (HEX != sample)  cnt <= 4'd0;
      else if (cnt != SAT) cnt <= cnt + 4'd1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= WAIT;
    else       state <= state_nxt;
  end

  // Next state: only an acceptance moves the FSM
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = legal ? LOCK : BAD;
  end

  assign valid = (state == LOCK);
  assign err   = (state == BAD);

  // Held digit and step pulses; pulses only compare when moving LOCK->LOCK
  always_ff @(posedge clk) begin
    if (reset) begin
      digit   <= 4'd0;
      incrOut <= 1'b0;
      wrapOut <= 1'b0;
    end else begin
      incrOut <= 1'b0;
      wrapOut <= 1'b0;
      if (accept && legal) begin
        digit <= value;
        if (state == LOCK) begin
          incrOut <= (value == digit_inc);
          wrapOut <= (digit == 4'd9) && (value == 4'd0);
        end
      end
    end
  end

`ifdef HEX_READER_JUMP_EN
  // Jump pulse: any change other than a +1 mod 10 step
  always_ff @(posedge clk) begin
    if (reset) begin
      jump <= 1'b0;
    end else begin
      jump <= 1'b0;
      if (accept && legal && (state == LOCK))
        jump <= (value != digit) && (value != digit_inc);
    end
  end
`else
  assign jump = 1'b0;
`endif

endmodule
